// File: rtl/multi_voice_sine_scheduler.sv
// Time-multiplexes one shared sine lookup datapath across NV phase-accumulating voices and mixes them.
// Optional feature: define MVSS_OVERRUN_CNT_EN to add a saturating count of dropped generate_next pulses.
module multi_voice_sine_scheduler #(
    parameter int NV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             generate_next,
    input  logic [NV*20-1:0] step_sizes,
    input  logic [NV-1:0]    voice_en,
    output logic             lookup_req,
    output logic [21:0]      lookup_phase,
    input  logic [15:0]      lookup_sample,
    input  logic             lookup_valid,
    output logic [15:0]      sample,
    output logic             sample_ready,
    output logic             busy
`ifdef MVSS_OVERRUN_CNT_EN
    ,
    output logic [7:0]       overrun_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NV - 1);

    state_t             state_r;
    logic [1:0]         idx_r;
    logic signed [17:0] acc_r;
    logic [21:0]        phase_r [NV];

    logic [21:0]        cur_step_s;
    logic signed [17:0] acc_sum_s;

    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'h7FFF;
        end else if (v < -18'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Per-voice step and the accumulator including the sample being returned now.
    always_comb begin
        cur_step_s = {2'b00, step_sizes[idx_r*20 +: 20]};
        acc_sum_s  = acc_r + {{2{lookup_sample[15]}}, lookup_sample};
    end

    assign lookup_req   = (state_r == ISSUE) && voice_en[idx_r];
    assign lookup_phase = phase_r[idx_r];

    // Frame sequencer: issue / wait per voice, then publish the saturated mix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= 2'd0;
            acc_r        <= 18'sd0;
            sample       <= 16'd0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < NV; i++) begin
                phase_r[i] <= 22'd0;
            end
        end else begin
            sample_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (generate_next) begin
                        acc_r   <= 18'sd0;
                        idx_r   <= 2'd0;
                        state_r <= ISSUE;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (voice_en[idx_r]) begin
                        state_r <= WAIT;
                    end else begin
                        phase_r[idx_r] <= 22'd0;
                        if (idx_r == LAST_IDX) begin
                            state_r      <= DONE;
                            sample_ready <= 1'b1;
                            sample       <= sat16(acc_r);
                        end else begin
                            idx_r <= idx_r + 2'd1;
                        end
                    end
                end
                WAIT: begin
                    if (lookup_valid) begin
                        acc_r          <= acc_sum_s;
                        phase_r[idx_r] <= phase_r[idx_r] + cur_step_s;
                        if (idx_r == LAST_IDX) begin
                            state_r      <= DONE;
                            sample_ready <= 1'b1;
                            sample       <= sat16(acc_sum_s);
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            state_r <= ISSUE;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MVSS_OVERRUN_CNT_EN
    // Counts requests dropped because a frame was already in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_count <= 8'd0;
        end else if (generate_next && (state_r != IDLE) && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'd1;
        end else begin
            overrun_count <= overrun_count;
        end
    end
`endif

endmodule

// File: tb/tb_multi_voice_sine_scheduler.sv
// Directed self-checking bench for multi_voice_sine_scheduler with a 2-cycle-latency sine datapath model.
module tb_multi_voice_sine_scheduler;

    localparam int NV = 3;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          generate_next;
    logic [59:0]   step_sizes;
    logic [2:0]    voice_en;
    logic          lookup_req;
    logic [21:0]   lookup_phase;
    logic [15:0]   lookup_sample;
    logic          lookup_valid;
    logic [15:0]   sample;
    logic          sample_ready;
    logic          busy;
`ifdef MVSS_OVERRUN_CNT_EN
    logic [7:0]    overrun_count;
`endif

    int total = 0;
    int bad   = 0;

    // datapath model state
    logic          pend;
    int            cnt;
    logic [21:0]   ph_q;
    logic          resp_valid;
    logic [15:0]   resp_sample;
    logic          stray_valid;
    logic [15:0]   resp_q[$];

    // per-frame observations
    int            got_lat;
    int            req_cnt;
    int            rdy_cnt;
    logic [21:0]   req_ph [8];

    multi_voice_sine_scheduler #(.NV(NV)) dut (
        .clk           (clk),
        .reset         (reset),
        .generate_next (generate_next),
        .step_sizes    (step_sizes),
        .voice_en      (voice_en),
        .lookup_req    (lookup_req),
        .lookup_phase  (lookup_phase),
        .lookup_sample (lookup_sample),
        .lookup_valid  (lookup_valid),
        .sample        (sample),
        .sample_ready  (sample_ready),
        .busy          (busy)
`ifdef MVSS_OVERRUN_CNT_EN
        ,
        .overrun_count (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    assign lookup_valid  = resp_valid | stray_valid;
    assign lookup_sample = stray_valid ? 16'd5000 : resp_sample;

    // Sine datapath stand-in: queued values if any, else phase[21:6]; valid L cycles after the request.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend        <= 1'b0;
            cnt         <= 0;
            resp_valid  <= 1'b0;
            resp_sample <= 16'd0;
        end else begin
            resp_valid <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    resp_valid <= 1'b1;
                    if (resp_q.size() > 0) resp_sample <= resp_q.pop_front();
                    else resp_sample <= ph_q[21:6];
                    pend <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (lookup_req) begin
                pend <= 1'b1;
                cnt  <= L - 1;
                ph_q <= lookup_phase;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_frame(input int ncyc, input int over_at);
        got_lat = -1;
        req_cnt = 0;
        rdy_cnt = 0;
        @(negedge clk);
        generate_next = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            generate_next = (k == over_at);
            if (lookup_req) begin
                if (req_cnt < 8) req_ph[req_cnt] = lookup_phase;
                req_cnt++;
            end
            if (sample_ready) begin
                rdy_cnt++;
                if (got_lat < 0) got_lat = k;
            end
        end
        generate_next = 1'b0;
    endtask

    task automatic test_reset();
        generate_next = 1'b0;
        stray_valid   = 1'b0;
        voice_en      = 3'b111;
        step_sizes    = {20'd4096, 20'd2048, 20'd1024};
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (sample !== 16'd0) begin bad++; $display("FAIL reset_sample got=%h exp=0000", sample); end
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", sample_ready); end
        total++; if (lookup_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", lookup_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef MVSS_OVERRUN_CNT_EN
        total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL reset_ovr got=%0d exp=0", overrun_count); end
`endif
    endtask

    task automatic test_mix();
        run_frame(14, 0);
        total++; if (got_lat !== 10) begin bad++; $display("FAIL mix1_latency got=%0d exp=10", got_lat); end
        total++; if (req_cnt !== 3) begin bad++; $display("FAIL mix1_reqs got=%0d exp=3", req_cnt); end
        total++; if (sample !== 16'd0) begin bad++; $display("FAIL mix1_sample got=%0d exp=0", sample); end
        run_frame(14, 0);
        total++; if (got_lat !== 10) begin bad++; $display("FAIL mix2_latency got=%0d exp=10", got_lat); end
        total++; if (req_ph[0] !== 22'd1024) begin bad++; $display("FAIL mix2_phase0 got=%0d exp=1024", req_ph[0]); end
        total++; if (req_ph[1] !== 22'd2048) begin bad++; $display("FAIL mix2_phase1 got=%0d exp=2048", req_ph[1]); end
        total++; if (req_ph[2] !== 22'd4096) begin bad++; $display("FAIL mix2_phase2 got=%0d exp=4096", req_ph[2]); end
        total++; if (sample !== 16'd112) begin bad++; $display("FAIL mix2_sample got=%0d exp=112", sample); end
        total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL mix2_ready_pulses got=%0d exp=1", rdy_cnt); end
    endtask

    task automatic test_saturation();
        resp_q.push_back(16'd30000);
        resp_q.push_back(16'd30000);
        resp_q.push_back(-16'sd1000);
        run_frame(14, 0);
        total++; if (sample !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h exp=7fff", sample); end
        repeat (3) resp_q.push_back(-16'sd20000);
        run_frame(14, 0);
        total++; if (sample !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h exp=8000", sample); end
        repeat (5) @(negedge clk);
        total++; if (sample !== 16'h8000) begin bad++; $display("FAIL sample_hold got=%h exp=8000", sample); end
    endtask

    task automatic test_skip();
        // phases are now 4096 / 8192 / 16384 after four frames
        voice_en = 3'b010;
        run_frame(10, 0);
        total++; if (got_lat !== 6) begin bad++; $display("FAIL skip_latency got=%0d exp=6", got_lat); end
        total++; if (req_cnt !== 1) begin bad++; $display("FAIL skip_reqs got=%0d exp=1", req_cnt); end
        total++; if (req_ph[0] !== 22'd8192) begin bad++; $display("FAIL skip_phase1 got=%0d exp=8192", req_ph[0]); end
        total++; if (sample !== 16'd128) begin bad++; $display("FAIL skip_sample got=%0d exp=128", sample); end
        voice_en = 3'b111;
        run_frame(14, 0);
        total++; if (req_ph[0] !== 22'd0) begin bad++; $display("FAIL skip_cleared0 got=%0d exp=0", req_ph[0]); end
        total++; if (req_ph[1] !== 22'd10240) begin bad++; $display("FAIL skip_phase1_next got=%0d exp=10240", req_ph[1]); end
        total++; if (req_ph[2] !== 22'd0) begin bad++; $display("FAIL skip_cleared2 got=%0d exp=0", req_ph[2]); end
        total++; if (sample !== 16'd160) begin bad++; $display("FAIL skip_sample_next got=%0d exp=160", sample); end
    endtask

    task automatic test_wrap();
        apply_reset();
        voice_en   = 3'b001;
        step_sizes = {20'd0, 20'd0, 20'hFFFFF};
        repeat (4) run_frame(8, 0);
        step_sizes = {20'd0, 20'd0, 20'd3};
        run_frame(8, 0);
        step_sizes = {20'd0, 20'd0, 20'hFFFFF};
        run_frame(8, 0);
        total++; if (req_ph[0] !== 22'h3FFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=3fffff", req_ph[0]); end
        run_frame(8, 0);
        total++; if (req_ph[0] !== 22'h0FFFFE) begin bad++; $display("FAIL wrap_post got=%h exp=0ffffe", req_ph[0]); end
        total++; if (got_lat !== 6) begin bad++; $display("FAIL wrap_latency got=%0d exp=6", got_lat); end
    endtask

    task automatic test_overrun();
        apply_reset();
        voice_en   = 3'b111;
        step_sizes = {20'd4096, 20'd2048, 20'd1024};
        resp_q.push_back(16'd100);
        resp_q.push_back(16'd200);
        resp_q.push_back(16'd300);
        run_frame(20, 2);
        total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL ovr_ready_pulses got=%0d exp=1", rdy_cnt); end
        total++; if (got_lat !== 10) begin bad++; $display("FAIL ovr_latency got=%0d exp=10", got_lat); end
        total++; if (req_cnt !== 3) begin bad++; $display("FAIL ovr_reqs got=%0d exp=3", req_cnt); end
        total++; if (sample !== 16'd600) begin bad++; $display("FAIL ovr_sample got=%0d exp=600", sample); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_idle got=%b exp=0", busy); end
`ifdef MVSS_OVERRUN_CNT_EN
        total++; if (overrun_count !== 8'd1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", overrun_count); end
`endif
    endtask

    task automatic test_reset_mid();
        int stray_rdy;
        stray_rdy = 0;
        @(negedge clk);
        generate_next = 1'b1;
        @(posedge clk);
        @(negedge clk);
        generate_next = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (sample !== 16'd0) begin bad++; $display("FAIL rst_mid_sample got=%0d exp=0", sample); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if (lookup_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b exp=0", lookup_req); end
        @(negedge clk);
        reset = 1'b0;
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (sample_ready) stray_rdy++;
            @(negedge clk);
        end
        total++; if (stray_rdy !== 0) begin bad++; $display("FAIL rst_mid_ready got=%0d exp=0", stray_rdy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_stray_busy got=%b exp=0", busy); end
        total++; if (sample !== 16'd0) begin bad++; $display("FAIL rst_mid_stray_sample got=%0d exp=0", sample); end
        resp_q.push_back(16'd1);
        resp_q.push_back(16'd2);
        resp_q.push_back(16'd3);
        run_frame(14, 0);
        total++; if (got_lat !== 10) begin bad++; $display("FAIL rst_next_latency got=%0d exp=10", got_lat); end
        total++; if (sample !== 16'd6) begin bad++; $display("FAIL rst_next_sample got=%0d exp=6", sample); end
        total++; if (req_ph[2] !== 22'd0) begin bad++; $display("FAIL rst_next_phase got=%0d exp=0", req_ph[2]); end
    endtask

    initial begin
        test_reset();
        test_mix();
        test_saturation();
        test_skip();
        test_wrap();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_voice_sine_scheduler.md
MULTI_VOICE_SINE_SCHEDULER -- requirements
Module: multi_voice_sine_scheduler

Interface
REQ-001 The block SHALL have parameter NV, default 3, meaning the number of voices (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-004 The block SHALL have port generate_next, input, 1, meaning a one-cycle request to produce the next mixed sample.
REQ-005 The block SHALL have port step_sizes, input, NV*20, meaning the unsigned per-voice phase increments, with voice i at bits [20i+19:20i].
REQ-006 The block SHALL have port voice_en, input, NV, meaning the per-voice enable.
REQ-007 The block SHALL have port lookup_req, output, 1, meaning a one-cycle lookup request to the shared sine datapath.
REQ-008 The block SHALL have port lookup_phase, output, 22, meaning the phase to look up, valid while lookup_req is high.
REQ-009 The block SHALL have port lookup_sample, input, 16, meaning the signed sine value returned by the datapath.
REQ-010 The block SHALL have port lookup_valid, input, 1, meaning lookup_sample is valid this cycle.
REQ-011 The block SHALL have port sample, output, 16, meaning the signed, saturated mix of all enabled voices.
REQ-012 The block SHALL have port sample_ready, output, 1, meaning a one-cycle pulse indicating that sample was updated.
REQ-013 The block SHALL have port busy, output, 1, meaning high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, with voice index idx and an 18-bit signed accumulator acc.
REQ-015 In IDLE, generate_next=1 SHALL set acc=0, set idx=0 and move the FSM to ISSUE; otherwise the FSM SHALL stay in IDLE.
REQ-016 In ISSUE with voice_en[idx]=1, the block SHALL drive lookup_req=1 and lookup_phase=phase[idx] for exactly one cycle, then move to WAIT.
REQ-017 In ISSUE with voice_en[idx]=0, the block SHALL clear phase[idx] to 0, issue no request, and advance idx, or move to DONE if idx=NV-1 (one cycle per skipped voice).
REQ-018 In WAIT, lookup_valid=1 SHALL add sign-extended lookup_sample to acc, set phase[idx] = phase[idx] + step (mod 2^22), then advance idx to ISSUE, or move to DONE if idx=NV-1.
REQ-019 In WAIT, the block SHALL wait indefinitely without timing out; lookup_valid outside WAIT SHALL be ignored.
REQ-020 On entry to DONE, sample SHALL be loaded with acc saturated to [-32768, 32767].
REQ-021 sample_ready SHALL be 1 exactly in the DONE cycle; the next state after DONE SHALL be IDLE.
REQ-022 sample SHALL hold its value between frames.
REQ-023 generate_next arriving while busy=1 SHALL be dropped, with no queuing.
REQ-024 Latency: with generate_next sampled in cycle 0, E enabled voices, NV-E disabled voices and a datapath returning valid L cycles after the request, sample_ready SHALL assert in cycle 1 + E*(L+1) + (NV-E).
REQ-025 voice_en and step_sizes SHALL be sampled at the ISSUE and WAIT cycles of each voice; changes mid-frame SHALL affect only voices not yet processed.

Reset
REQ-026 Asserting reset SHALL immediately force the FSM to IDLE, idx=0, acc=0, all phase registers to 0, sample=0, and sample_ready, lookup_req and busy to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no sample_ready; any later lookup_valid SHALL be ignored.

Configuration
REQ-028 When macro MVSS_OVERRUN_CNT_EN is defined, the block SHALL add output overrun_count [7:0], reset to 0, incremented on each dropped generate_next (REQ-023) and saturating at 255.
REQ-029 When MVSS_OVERRUN_CNT_EN is undefined, the overrun_count port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-030 NV=3, all voices enabled, steps 1024/2048/4096, L=2, model sample=phase[21:6]: generate_next at cycle 0 -> sample_ready in cycle 10; phases after frame 1 are 1024/2048/4096.
REQ-031 Voices returning 30000, 30000 and -1000 -> sample=32767 (saturation); three returning -20000 -> sample=-32768.
REQ-032 voice_en=3'b010, L=2 -> exactly one lookup_req, sample_ready in cycle 6, and phase[0] and phase[2] read as 0.
REQ-033 Step 20'hFFFFF with phase 22'h3FFFFF -> next phase 22'h0FFFFE (wrap-around).
REQ-034 generate_next pulsed during WAIT -> no extra frame; overrun_count=1 when the macro is defined.
REQ-035 Reset asserted during WAIT, then stray lookup_valid -> no sample_ready, sample=0, busy=0, and the next frame runs normally.
